// File: rtl/mem_fwd_source.sv
// mem_fwd_source: memory-stage producer of forwarding bundles.
//
// Latches the EX->MEM bundle, runs the data-bus handshake for loads and
// stores, formats load data, and publishes the stage result both as a
// combinational bypass (mem_fwd) and as a registered writeback bundle (wb_*).
// While a bus access is outstanding the upstream pipeline is held.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   in_valid/in_ready          EX bundle handshake
//   in_dst, in_wen, in_result  destination, write enable, ALU result / address
//   in_load, in_store          memory op kind (never both)
//   in_size, in_unsigned       access size (0 B,1 H,2 W,3 D), zero-extend load
//   in_wdata                   store data, right-aligned
//   dreq_*                     data-bus request (valid, addr, size, strobe, data)
//   dresp_data_ok, dresp_data  data-bus completion and 8-byte-aligned read data
//   mem_fwd                    fwd_data_t bypass {valid, dst, data}
//   wb_valid/wen/dst/data      registered writeback bundle
//   mem_stall                  pipeline hold
//
// Build option: define MEM_FWD_LOAD_EN to let loads drive mem_fwd.valid once
// their data is captured; otherwise loads never assert mem_fwd.valid.

package mem_fwd_pkg;
    typedef struct packed {
        logic        valid;
        logic [4:0]  dst;
        logic [63:0] data;
    } fwd_data_t;
endpackage

module mem_fwd_source #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_dst,
    input  logic                  in_wen,
    input  logic [DATA_W-1:0]     in_result,
    input  logic                  in_load,
    input  logic                  in_store,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
    input  logic [DATA_W-1:0]     in_wdata,
    output logic                  dreq_valid,
    output logic [ADDR_W-1:0]     dreq_addr,
    output logic [1:0]            dreq_size,
    output logic [7:0]            dreq_strobe,
    output logic [DATA_W-1:0]     dreq_data,
    input  logic                  dresp_data_ok,
    input  logic [DATA_W-1:0]     dresp_data,
    output mem_fwd_pkg::fwd_data_t mem_fwd,
    output logic                  wb_valid,
    output logic                  wb_wen,
    output logic [4:0]            wb_dst,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  mem_stall
);

    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] READY  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]        state;
    logic [4:0]        h_dst;
    logic              h_wen;
    logic [DATA_W-1:0] h_result;
    logic              h_load;
    logic              h_store;
    logic [1:0]        h_size;
    logic              h_unsigned;
    logic [DATA_W-1:0] h_wdata;

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_fmt;
    logic [7:0]        size_mask;
    logic              load_ok;

    assign in_ready   = (state != ACCESS);
    assign dreq_valid = (state == ACCESS);
    assign mem_stall  = (state == ACCESS) && !dresp_data_ok;

    assign dreq_addr = h_result[ADDR_W-1:0];
    assign dreq_size = h_size;
    assign dreq_data = h_wdata << {h_result[2:0], 3'b000};

    always_comb begin
        size_mask = 8'h01;
        case (h_size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Oversized masks on misaligned addresses simply fall off the top lane.
    assign dreq_strobe = h_store ? (size_mask << h_result[2:0]) : 8'h00;

    // Only the low address bits steer the lane; misalignment is not trapped.
    assign shifted = dresp_data >> {h_result[2:0], 3'b000};

    always_comb begin
        load_fmt = shifted;
        case (h_size)
            2'd0: load_fmt = h_unsigned ? {56'd0, shifted[7:0]}
                                        : {{56{shifted[7]}}, shifted[7:0]};
            2'd1: load_fmt = h_unsigned ? {48'd0, shifted[15:0]}
                                        : {{48{shifted[15]}}, shifted[15:0]};
            2'd2: load_fmt = h_unsigned ? {32'd0, shifted[31:0]}
                                        : {{32{shifted[31]}}, shifted[31:0]};
            default: load_fmt = shifted;
        endcase
    end

`ifdef MEM_FWD_LOAD_EN
    assign load_ok = 1'b1;
`else
    // Loads are never bypassed; decode interlocks load-use and waits for wb.
    assign load_ok = !h_load;
`endif

    // READY is the only state in which the held result is final.
    assign mem_fwd.valid = (state == READY) && h_wen && (h_dst != 5'd0) && load_ok;
    assign mem_fwd.dst   = h_dst;
    assign mem_fwd.data  = h_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            h_dst      <= '0;
            h_wen      <= 1'b0;
            h_result   <= '0;
            h_load     <= 1'b0;
            h_store    <= 1'b0;
            h_size     <= '0;
            h_unsigned <= 1'b0;
            h_wdata    <= '0;
            wb_valid   <= 1'b0;
            wb_wen     <= 1'b0;
            wb_dst     <= '0;
            wb_data    <= '0;
        end else begin
            // Each bundle spends exactly one cycle in READY, so this pulses once.
            wb_valid <= (state == READY);
            wb_wen   <= (state == READY) && h_wen;
            wb_dst   <= h_dst;
            wb_data  <= h_result;

            if (in_valid && in_ready) begin
                h_dst      <= in_dst;
                h_wen      <= in_wen;
                h_result   <= in_result;
                h_load     <= in_load;
                h_store    <= in_store;
                h_size     <= in_size;
                h_unsigned <= in_unsigned;
                h_wdata    <= in_wdata;
                state      <= (in_load || in_store) ? ACCESS : READY;
            end else begin
                case (state)
                    READY: state <= EMPTY;
                    ACCESS: begin
                        if (dresp_data_ok) begin
                            state <= READY;
                            if (h_load) h_result <= load_fmt;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_fwd_source.sv
// Self-checking bench for mem_fwd_source: writeback scoreboard plus direct
// checks of bypass, bus request and stall timing.
module tb_mem_fwd_source;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_dst = '0;
    logic        in_wen = 1'b0;
    logic [63:0] in_result = '0;
    logic        in_load = 1'b0;
    logic        in_store = 1'b0;
    logic [1:0]  in_size = '0;
    logic        in_unsigned = 1'b0;
    logic [63:0] in_wdata = '0;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok = 1'b0;
    logic [63:0] dresp_data = '0;
    mem_fwd_pkg::fwd_data_t mem_fwd;
    logic        wb_valid;
    logic        wb_wen;
    logic [4:0]  wb_dst;
    logic [63:0] wb_data;
    logic        mem_stall;

    mem_fwd_source dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dst(in_dst), .in_wen(in_wen), .in_result(in_result),
        .in_load(in_load), .in_store(in_store), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_wdata(in_wdata),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .mem_fwd(mem_fwd),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_dst(wb_dst), .wb_data(wb_data),
        .mem_stall(mem_stall)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int wb_cnt = 0;
    logic [69:0] sb[$];

`ifdef MEM_FWD_LOAD_EN
    localparam logic LD_FV = 1'b1;
`else
    localparam logic LD_FV = 1'b0;
`endif

    task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Writeback scoreboard: compare each wb pulse against the oldest expected.
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            wb_cnt++;
            if (sb.size() == 0) chk("sb_underflow", 70'd1, 70'd0);
            else chk("wb_bundle", {wb_wen, wb_dst, wb_data}, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic set_in(input logic [4:0] dst, input logic wen, input logic [63:0] res,
                          input logic ld, input logic st, input logic [1:0] sz,
                          input logic uns, input logic [63:0] wd);
        in_valid = 1'b1; in_dst = dst; in_wen = wen; in_result = res;
        in_load = ld; in_store = st; in_size = sz; in_unsigned = uns; in_wdata = wd;
    endtask

    logic [7:0]  obs_strobe;
    logic [63:0] obs_dreq_data;

    // Memory op with completion on the lat-th ACCESS cycle; ends at M+1.
    task automatic mem_op(input string tag, input logic [4:0] dst, input logic wen,
                          input logic [63:0] addr, input logic ld, input logic st,
                          input logic [1:0] sz, input logic uns, input logic [63:0] wd,
                          input logic [63:0] rdata, input int lat,
                          input logic [63:0] exp_data, input logic exp_fv);
        int stalls;
        @(negedge clk);
        set_in(dst, wen, addr, ld, st, sz, uns, wd);
        sb.push_back({wen, dst, exp_data});
        @(negedge clk);
        in_valid = 1'b0;
        stalls = 0;
        for (int i = 1; i <= lat; i++) begin
            if (i > 1) @(negedge clk);
            chk({tag, "_dreq_valid"}, dreq_valid, 1'b1);
            if (i == 1) begin
                chk({tag, "_in_ready"}, in_ready, 1'b0);
                chk({tag, "_addr"}, dreq_addr, addr);
                obs_strobe = dreq_strobe;
                obs_dreq_data = dreq_data;
            end
            dresp_data_ok = (i == lat);
            dresp_data = rdata;
            #1;
            if (mem_stall) stalls++;
        end
        @(negedge clk);
        dresp_data_ok = 1'b0;
        chk({tag, "_dreq_drop"}, dreq_valid, 1'b0);
        chk({tag, "_fwd_valid"}, mem_fwd.valid, exp_fv);
        chk({tag, "_fwd_data"}, mem_fwd.data, exp_data);
        chk({tag, "_stalls"}, stalls, lat - 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int base;

    initial begin
        // Reset state
        idle(2);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_mem_fwd", mem_fwd, 70'd0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_dreq_valid", dreq_valid, 1'b0);
        chk("rst_stall", mem_stall, 1'b0);
        reset = 1'b0;

        // ALU op: bypass next cycle, one wb pulse the cycle after
        @(negedge clk);
        set_in(5'd5, 1'b1, 64'h1234, 1'b0, 1'b0, 2'd3, 1'b0, 64'd0);
        sb.push_back({1'b1, 5'd5, 64'h1234});
        @(negedge clk);
        in_valid = 1'b0;
        chk("alu_fwd", mem_fwd, {1'b1, 5'd5, 64'h1234});
        chk("alu_wb_early", wb_valid, 1'b0);
        @(negedge clk);
        chk("alu_fwd_clear", mem_fwd.valid, 1'b0);
        chk("alu_wb_pulse", wb_valid, 1'b1);
        @(negedge clk);
        chk("alu_wb_once", wb_valid, 1'b0);

        // dst = 0 never bypasses
        set_in(5'd0, 1'b1, 64'h77, 1'b0, 1'b0, 2'd3, 1'b0, 64'd0);
        sb.push_back({1'b1, 5'd0, 64'h77});
        @(negedge clk);
        in_valid = 1'b0;
        chk("dst0_fwd_valid", mem_fwd.valid, 1'b0);

        // Back-to-back ALU ops, one per cycle
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            set_in(5'(k), 1'b1, 64'(k * 'h11), 1'b0, 1'b0, 2'd3, 1'b0, 64'd0);
            sb.push_back({1'b1, 5'(k), 64'(k * 'h11)});
            @(negedge clk);
            chk("b2b_fwd", mem_fwd, {1'b1, 5'(k), 64'(k * 'h11)});
        end
        in_valid = 1'b0;
        idle(2);

        // Store byte with a 3-cycle response delay
        mem_op("st_b", 5'd0, 1'b0, 64'h8000_0003, 1'b0, 1'b1, 2'd0, 1'b0, 64'hAB,
               64'd0, 3, 64'h8000_0003, 1'b0);
        chk("st_strobe", obs_strobe, 8'h08);
        chk("st_lane", obs_dreq_data[31:24], 8'hAB);

        // Half loads at offset 6, zero-wait signed, 3-cycle unsigned
        mem_op("ld_hs", 5'd7, 1'b1, 64'h1006, 1'b1, 1'b0, 2'd1, 1'b0, 64'd0,
               64'h8001_0000_0000_0000, 1, 64'hFFFF_FFFF_FFFF_8001, LD_FV);
        chk("ld_strobe", obs_strobe, 8'h00);
        mem_op("ld_hu", 5'd7, 1'b1, 64'h1006, 1'b1, 1'b0, 2'd1, 1'b1, 64'd0,
               64'h8001_0000_0000_0000, 3, 64'h8001, LD_FV);
        mem_op("ld_bs", 5'd8, 1'b1, 64'h2001, 1'b1, 1'b0, 2'd0, 1'b0, 64'd0,
               64'h0000_0000_0000_F500, 2, 64'hFFFF_FFFF_FFFF_FFF5, LD_FV);
        mem_op("ld_ws", 5'd9, 1'b1, 64'h2004, 1'b1, 1'b0, 2'd2, 1'b0, 64'd0,
               64'hDEAD_BEEF_0000_0000, 1, 64'hFFFF_FFFF_DEAD_BEEF, LD_FV);
        mem_op("ld_wu", 5'd9, 1'b1, 64'h2004, 1'b1, 1'b0, 2'd2, 1'b1, 64'd0,
               64'hDEAD_BEEF_0000_0000, 1, 64'h0000_0000_DEAD_BEEF, LD_FV);
        mem_op("ld_d", 5'd10, 1'b1, 64'h2000, 1'b1, 1'b0, 2'd3, 1'b0, 64'd0,
               64'h1122_3344_5566_7788, 2, 64'h1122_3344_5566_7788, LD_FV);
        mem_op("st_h", 5'd0, 1'b0, 64'h3002, 1'b0, 1'b1, 2'd1, 1'b0, 64'hBEEF,
               64'd0, 1, 64'h3002, 1'b0);
        chk("st_h_strobe", obs_strobe, 8'h0C);
        chk("st_h_data", obs_dreq_data, 64'h0000_0000_BEEF_0000);
        idle(3);

        // Async reset mid-ACCESS; the held load is discarded
        @(negedge clk);
        set_in(5'd11, 1'b1, 64'h40, 1'b1, 1'b0, 2'd3, 1'b0, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_pre_dreq", dreq_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_dreq", dreq_valid, 1'b0);
        chk("rst_mid_ready", in_ready, 1'b1);
        chk("rst_mid_fwd", mem_fwd, 70'd0);
        chk("rst_mid_addr", dreq_addr, 64'd0);
        chk("rst_mid_stall", mem_stall, 1'b0);
        chk("rst_mid_wb", wb_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        chk("rst_post_wb", wb_valid, 1'b0);

        // in_valid held through ACCESS, completion in the same cycle
        base = wb_cnt;
        @(negedge clk);
        set_in(5'd12, 1'b1, 64'h48, 1'b1, 1'b0, 2'd3, 1'b0, 64'd0);
        sb.push_back({1'b1, 5'd12, 64'hCAFE_F00D_0000_0001});
        @(negedge clk);
        set_in(5'd13, 1'b1, 64'h55, 1'b0, 1'b0, 2'd3, 1'b0, 64'd0);
        sb.push_back({1'b1, 5'd13, 64'h55});
        dresp_data_ok = 1'b1;
        dresp_data = 64'hCAFE_F00D_0000_0001;
        #1;
        chk("hold_in_ready", in_ready, 1'b0);
        chk("hold_stall", mem_stall, 1'b0);
        @(negedge clk);
        dresp_data_ok = 1'b0;
        chk("hold_ready_after", in_ready, 1'b1);
        chk("hold_ld_fwd", mem_fwd, {LD_FV, 5'd12, 64'hCAFE_F00D_0000_0001});
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_alu_fwd", mem_fwd, {1'b1, 5'd13, 64'h55});
        idle(4);
        chk("hold_wb_count", wb_cnt - base, 2);

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
